// File: rtl/uart_pkg.sv
// uart_pkg: constants and FSM state encoding shared by the UART transmitter
// and receiver so both ends agree on frame layout.
// Contents: DATA_BITS, START_BIT, STOP_BIT, state_t.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue between the host interface and the serialiser.
// Ports: clock, reset (async, active-high), push/wdata (write side),
//        pop/rdata (read side, rdata shows the head), full/empty (registered).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int depth = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 full,
  output logic                 empty
);

  localparam int aw = (depth > 1) ? $clog2(depth) : 1;

  // One extra pointer bit distinguishes full from empty when addresses match.
  logic [aw:0]          wptr, rptr, wptr_next, rptr_next;
  logic [DATA_BITS-1:0] mem [0:depth-1];
  logic                 do_push, do_pop;

  // Flags are registered, so a push while full is refused even if a pop
  // frees a slot on the same edge.
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign wptr_next = wptr + {{aw{1'b0}}, do_push};
  assign rptr_next = rptr + {{aw{1'b0}}, do_pop};
  assign rdata     = mem[rptr[aw-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wptr  <= wptr_next;
      rptr  <= rptr_next;
      full  <= (wptr_next[aw-1:0] == rptr_next[aw-1:0]) &&
               (wptr_next[aw] != rptr_next[aw]);
      empty <= (wptr_next == rptr_next);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wptr[aw-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: queued 8N1 serial transmitter; frames leave back-to-back while bytes wait.
// Ports: clock, reset (async, active-high), txdata/txvalid/txready (byte input
//        handshake), tx (registered serial line, idle high), txbusy (registered).
module uart_tx
  import uart_pkg::*;
#(
  parameter int clockperbit = 10,
  parameter int depth       = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] txdata,
  input  logic                 txvalid,
  output logic                 txready,
  output logic                 tx,
  output logic                 txbusy
);

  localparam int             cw       = (clockperbit > 1) ? $clog2(clockperbit) : 1;
  localparam logic [cw-1:0]  reload   = cw'(clockperbit - 1);
  localparam logic [2:0]     last_bit = 3'(DATA_BITS - 1);

  state_t               state;
  logic [cw-1:0]        count;
  logic [2:0]           bitidx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] head;
  logic                 full, empty, pop;

  // Pop exactly on the edges where the FSM loads a new byte: leaving IDLE,
  // or chaining straight from the end of a stop bit into the next start bit.
  assign pop     = !empty && ((state == IDLE) || ((state == STOP) && (count == '0)));
  assign txready = !full;

  uart_tx_fifo #(
    .depth(depth)
  ) fifo (
    .clock(clock),
    .reset(reset),
    .push (txvalid),
    .pop  (pop),
    .wdata(txdata),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      bitidx <= '0;
      shift  <= '0;
      tx     <= STOP_BIT;
      txbusy <= 1'b0;
    end else begin
      txbusy <= (state != IDLE) || !empty;
      case (state)
        IDLE: begin
          if (!empty) begin
            shift <= head;
            tx    <= START_BIT;
            count <= reload;
            state <= START;
          end
        end
        START: begin
          if (count == '0) begin
            tx     <= shift[0];
            shift  <= shift >> 1;
            count  <= reload;
            bitidx <= '0;
            state  <= DATA;
          end else begin
            count <= count - cw'(1);
          end
        end
        DATA: begin
          if (count == '0) begin
            count <= reload;
            if (bitidx == last_bit) begin
              tx    <= STOP_BIT;
              state <= STOP;
            end else begin
              tx     <= shift[0];
              shift  <= shift >> 1;
              bitidx <= bitidx + 3'd1;
            end
          end else begin
            count <= count - cw'(1);
          end
        end
        STOP: begin
          if (count == '0) begin
            if (!empty) begin
              shift <= head;
              tx    <= START_BIT;
              count <= reload;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            count <= count - cw'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx at clockperbit=10 and clockperbit=2.
// Expected line levels come from a frame-level model built from the accepted bytes.
module tb_uart_tx;

  logic       clock;
  logic       reset;
  logic [7:0] txdata,  txdata2;
  logic       txvalid, txvalid2;
  logic       txready, txready2;
  logic       tx,      tx2;
  logic       txbusy,  txbusy2;

  uart_tx #(.clockperbit(10), .depth(4)) dut (
    .clock(clock), .reset(reset), .txdata(txdata), .txvalid(txvalid),
    .txready(txready), .tx(tx), .txbusy(txbusy)
  );

  uart_tx #(.clockperbit(2), .depth(4)) dut2 (
    .clock(clock), .reset(reset), .txdata(txdata2), .txvalid(txvalid2),
    .txready(txready2), .tx(tx2), .txbusy(txbusy2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Bytes accepted in the current scenario and the edge number that took each one.
  logic [7:0] acc_b[$];
  int         acc_c[$];
  logic       obs_tx, obs_rdy, obs_busy;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  // Line level after edge c: each frame starts one edge after its byte was
  // accepted, but never before the previous frame's 10 bits have finished.
  function automatic logic model_tx(input int c, input int cpb);
    int prev_end = -1000000;
    int st;
    for (int i = 0; i < acc_b.size(); i++) begin
      st = (acc_c[i] + 1 > prev_end) ? acc_c[i] + 1 : prev_end;
      if (c >= st && c < st + 10 * cpb) return frame_bit(acc_b[i], (c - st) / cpb);
      prev_end = st + 10 * cpb;
    end
    return 1'b1;
  endfunction

  task automatic clear_model();
    acc_b.delete();
    acc_c.delete();
  endtask

  // Drive one cycle of input, note an accept, take edge n, sample 1 time unit later.
  task automatic step(input bit sel, input logic v, input logic [7:0] d, input int n);
    logic acc;
    if (sel) begin
      txvalid2 = v; txdata2 = d; acc = v && txready2;
    end else begin
      txvalid = v;  txdata = d;  acc = v && txready;
    end
    if (acc) begin
      acc_b.push_back(d);
      acc_c.push_back(n);
    end
    @(posedge clock);
    #1;
    obs_tx   = sel ? tx2 : tx;
    obs_rdy  = sel ? txready2 : txready;
    obs_busy = sel ? txbusy2 : txbusy;
  endtask

  task automatic test_reset();
    txvalid = 1'b0; txdata = 8'h00; txvalid2 = 1'b0; txdata2 = 8'h00;
    reset = 1'b0;
    #1 reset = 1'b1;
    #12;
    checks++; if (tx !== 1'b1)      begin failures++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (txready !== 1'b1) begin failures++; $display("FAIL reset_txready: got %b want 1", txready); end
    checks++; if (txbusy !== 1'b0)  begin failures++; $display("FAIL reset_txbusy: got %b want 0", txbusy); end
    @(negedge clock);
    reset = 1'b0;
    for (int n = 1; n <= 3; n++) step(0, 1'b0, 8'($urandom), n);
  endtask

  task automatic test_single_55();
    int bad = 0, first = -1;
    logic [9:0] pat = '0;
    clear_model();
    for (int n = 1; n <= 110; n++) begin
      step(0, n == 1, (n == 1) ? 8'h55 : 8'($urandom), n);
      if (obs_tx !== model_tx(n, 10)) begin bad++; if (first < 0) first = n; end
      if (n == 1) begin checks++; if (obs_tx !== 1'b1) begin failures++; $display("FAIL single_no_early_start: got %b want 1", obs_tx); end end
      if (n == 2) begin checks++; if (obs_tx !== 1'b0) begin failures++; $display("FAIL single_start_latency: got %b want 0", obs_tx); end end
      if (n == 2) begin checks++; if (obs_busy !== 1'b1) begin failures++; $display("FAIL single_busy_rise: got %b want 1", obs_busy); end end
      if (n >= 2 && (n - 2) % 10 == 5 && (n - 2) / 10 < 10) pat[(n - 2) / 10] = obs_tx;
      if (n == 102) begin checks++; if (obs_busy !== 1'b1) begin failures++; $display("FAIL single_busy_hold: got %b want 1", obs_busy); end end
      if (n == 103) begin checks++; if (obs_busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall: got %b want 0", obs_busy); end end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL single_wave: %0d bad cycles (first %0d), want 0", bad, first); end
    checks++; if (pat !== 10'b1010101010) begin failures++; $display("FAIL single_pattern: got %b want 1010101010", pat); end
  endtask

  task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1);
    int bad = 0, first = -1;
    logic [7:0] rx0 = '0, rx1 = '0;
    clear_model();
    for (int n = 1; n <= 215; n++) begin
      step(0, n <= 2, (n == 1) ? b0 : (n == 2) ? b1 : 8'($urandom), n);
      if (obs_tx !== model_tx(n, 10)) begin bad++; if (first < 0) first = n; end
      // Receiver: sample data bit i at its centre in each frame.
      for (int i = 0; i < 8; i++) begin
        if (n == 2 + 10 * (i + 1) + 5)   rx0[i] = obs_tx;
        if (n == 102 + 10 * (i + 1) + 5) rx1[i] = obs_tx;
      end
      if (n == 101) begin checks++; if (obs_tx !== 1'b1) begin failures++; $display("FAIL b2b_stop_end: got %b want 1", obs_tx); end end
      if (n == 102) begin checks++; if (obs_tx !== 1'b0) begin failures++; $display("FAIL b2b_no_gap: got %b want 0", obs_tx); end end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL b2b_wave: %0d bad cycles (first %0d), want 0", bad, first); end
    checks++; if (rx0 !== b0) begin failures++; $display("FAIL b2b_rx0: got %h want %h", rx0, b0); end
    checks++; if (rx1 !== b1) begin failures++; $display("FAIL b2b_rx1: got %h want %h", rx1, b1); end
  endtask

  task automatic test_fill();
    int bad = 0, first = -1, first_low = -1, acc_at_low = -1;
    logic [7:0] base = 8'($urandom);
    logic v;
    clear_model();
    for (int n = 1; n <= 810; n++) begin
      v = (acc_b.size() < 8);
      step(0, v, v ? 8'(base + 8'(acc_b.size())) : 8'($urandom), n);
      if (obs_tx !== model_tx(n, 10)) begin bad++; if (first < 0) first = n; end
      if (!obs_rdy && first_low < 0) begin first_low = n; acc_at_low = acc_b.size(); end
      if (n == 101) begin checks++; if (obs_rdy !== 1'b0) begin failures++; $display("FAIL fill_ready_held: got %b want 0", obs_rdy); end end
      if (n == 102) begin checks++; if (obs_rdy !== 1'b1) begin failures++; $display("FAIL fill_ready_after_pop: got %b want 1", obs_rdy); end end
    end
    checks++; if (acc_at_low != 5) begin failures++; $display("FAIL fill_accepts_before_full: got %0d want 5", acc_at_low); end
    checks++; if (acc_c.size() < 6 || acc_c[5] != 103) begin failures++; $display("FAIL fill_sixth_accept_edge: got %0d want 103", (acc_c.size() < 6) ? -1 : acc_c[5]); end
    checks++; if (bad != 0) begin failures++; $display("FAIL fill_wave: %0d bad cycles (first %0d), want 0", bad, first); end
    checks++; if (obs_busy !== 1'b0) begin failures++; $display("FAIL fill_busy_end: got %b want 0", obs_busy); end
  endtask

  task automatic test_reset_midframe();
    int bad = 0, first = -1;
    clear_model();
    for (int n = 1; n <= 38; n++) begin
      // First byte has bit 2 clear so the line is low at frame cycle 37.
      step(0, n <= 3, (n == 1) ? (8'($urandom) & 8'hFB) : 8'($urandom), n);
      if (obs_tx !== model_tx(n, 10)) begin bad++; if (first < 0) first = n; end
    end
    checks++; if (bad != 0 || obs_tx !== 1'b0) begin failures++; $display("FAIL rst_pre_wave: %0d bad cycles, tx=%b want 0 bad, tx 0", bad, obs_tx); end
    #2 reset = 1'b1;
    #1;
    checks++; if (tx !== 1'b1)      begin failures++; $display("FAIL rst_mid_tx: got %b want 1", tx); end
    checks++; if (txready !== 1'b1) begin failures++; $display("FAIL rst_mid_txready: got %b want 1", txready); end
    checks++; if (txbusy !== 1'b0)  begin failures++; $display("FAIL rst_mid_txbusy: got %b want 0", txbusy); end
    @(posedge clock);
    #1 reset = 1'b0;
    bad = 0;
    for (int n = 1; n <= 250; n++) begin
      step(0, 1'b0, 8'($urandom), n);
      if (obs_tx !== 1'b1 || obs_busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rst_no_resume: %0d active cycles, want 0", bad); end
    clear_model();
    bad = 0; first = -1;
    for (int n = 1; n <= 110; n++) begin
      step(0, n == 1, 8'($urandom), n);
      if (obs_tx !== model_tx(n, 10)) begin bad++; if (first < 0) first = n; end
      if (n == 2) begin checks++; if (obs_tx !== 1'b0) begin failures++; $display("FAIL rst_first_latency: got %b want 0", obs_tx); end end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rst_after_wave: %0d bad cycles (first %0d), want 0", bad, first); end
  endtask

  task automatic test_cpb2();
    int bad = 0, first = -1;
    clear_model();
    for (int n = 1; n <= 50; n++) begin
      step(1, n <= 2, (n == 1) ? 8'hFF : (n == 2) ? 8'h00 : 8'($urandom), n);
      if (obs_tx !== model_tx(n, 2)) begin bad++; if (first < 0) first = n; end
      if (n == 21) begin checks++; if (obs_tx !== 1'b1) begin failures++; $display("FAIL cpb2_f1_stop: got %b want 1", obs_tx); end end
      if (n == 22) begin checks++; if (obs_tx !== 1'b0) begin failures++; $display("FAIL cpb2_f2_start: got %b want 0", obs_tx); end end
      if (n == 39) begin checks++; if (obs_tx !== 1'b0) begin failures++; $display("FAIL cpb2_f2_last_data: got %b want 0", obs_tx); end end
      if (n == 40 || n == 41) begin checks++; if (obs_tx !== 1'b1) begin failures++; $display("FAIL cpb2_f2_stop: cycle %0d got %b want 1", n, obs_tx); end end
      if (n == 42) begin checks++; if (obs_busy !== 1'b1) begin failures++; $display("FAIL cpb2_busy_hold: got %b want 1", obs_busy); end end
      if (n == 43) begin checks++; if (obs_busy !== 1'b0) begin failures++; $display("FAIL cpb2_busy_fall: got %b want 0", obs_busy); end end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL cpb2_wave: %0d bad cycles (first %0d), want 0", bad, first); end
  endtask

  task automatic test_random();
    int bad = 0, first = -1;
    logic v;
    clear_model();
    for (int n = 1; n <= 1400; n++) begin
      v = (acc_b.size() < 10) && ($urandom_range(0, 3) == 0);
      step(0, v, 8'($urandom), n);
      if (obs_tx !== model_tx(n, 10)) begin bad++; if (first < 0) first = n; end
    end
    checks++; if (acc_b.size() != 10) begin failures++; $display("FAIL rand_accepts: got %0d want 10", acc_b.size()); end
    checks++; if (bad != 0) begin failures++; $display("FAIL rand_wave: %0d bad cycles (first %0d), want 0", bad, first); end
    checks++; if (obs_busy !== 1'b0 || obs_rdy !== 1'b1) begin failures++; $display("FAIL rand_idle_end: busy=%b ready=%b want busy 0 ready 1", obs_busy, obs_rdy); end
  endtask

  initial begin
    test_reset();
    test_single_55();
    test_back_to_back(8'hA5, 8'h3C);
    test_back_to_back(8'($urandom), 8'($urandom));
    test_fill();
    test_reset_midframe();
    test_cpb2();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
